// File: rtl/bus_arbiter_if.sv
// Bus bundle between the requesters (master side) and bus_arbiter (slave side).
// Carries the request/grant handshake, the four requester lanes and the shared output bus.
interface bus_arbiter_if #(
    parameter int DW = 4
);
    logic              en;
    logic [3:0]        req;
    logic [3:0]        lock;
    logic [4*DW-1:0]   a;
    logic [3:0]        gnt;
    logic [DW-1:0]     b;
    logic              b_valid;
    logic [1:0]        b_src;

    modport master (
        output en, req, lock, a,
        input  gnt, b, b_valid, b_src
    );

    modport slave (
        input  en, req, lock, a,
        output gnt, b, b_valid, b_src
    );
endinterface

// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter with a two-stage registered data path.
// Define BUS_ARB_LOCK_EN to enable locked bursts of up to BURST_MAX grants to one requester.
module bus_arbiter #(
    parameter int DW        = 4,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [1:0]    own;
    logic [3:0]    cnt;

    logic [DW-1:0] s1_data, s2_data;
    logic          s1_valid, s2_valid;
    logic [1:0]    s1_src, s2_src;

    logic [1:0]    win;
    logic          win_hit;
    logic [1:0]    cand;
    logic [3:0]    gnt_c;
    logic [1:0]    g_idx;
    logic          grant;

    // Round-robin search: scan from the farthest candidate back to ptr so the
    // nearest set bit at or after ptr is the last one written.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        win     = ptr;
        win_hit = 1'b0;
        cand    = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (bus.req[cand]) begin
                win     = cand;
                win_hit = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_c = '0;
        g_idx = (state == LOCKED) ? own : win;
        if (!rst && bus.en) begin
            if (state == LOCKED) begin
                if (bus.req[own]) gnt_c[own] = 1'b1;
            end else if (win_hit) begin
                gnt_c[win] = 1'b1;
            end
        end
    end

    assign grant   = |gnt_c;
    assign bus.gnt = gnt_c;

    assign bus.b       = s2_data;
    assign bus.b_valid = s2_valid;
    assign bus.b_src   = s2_src;

`ifndef BUS_ARB_LOCK_EN
    assign own = '0;
    assign cnt = '0;
    localparam logic [3:0] unused_burst_max = 4'(BURST_MAX);
    logic unused_cfg;
    assign unused_cfg = ^{bus.lock, cnt};
`endif

    always_ff @(posedge clk) begin
        // NOTE: all registered state uses non-blocking assignment so stage S2 sees the old S1.
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_src   <= '0;
            s2_data  <= '0;
            s2_valid <= 1'b0;
            s2_src   <= '0;
            ptr      <= '0;
            state    <= ARB;
`ifdef BUS_ARB_LOCK_EN
            own      <= '0;
            cnt      <= '0;
`endif
        end else begin
            s2_data  <= s1_data;
            s2_valid <= s1_valid;
            s2_src   <= s1_src;

            if (grant) begin
                s1_data  <= bus.a[int'(g_idx)*DW +: DW];
                s1_valid <= 1'b1;
                s1_src   <= g_idx;
            end else begin
                s1_valid <= 1'b0;
            end

            if (!bus.en) begin
                state <= ARB;
`ifdef BUS_ARB_LOCK_EN
                cnt   <= '0;
`endif
            end else if (state == ARB) begin
                if (grant) begin
                    ptr <= win + 2'd1;
`ifdef BUS_ARB_LOCK_EN
                    if (bus.lock[win]) begin
                        state <= LOCKED;
                        own   <= win;
                        cnt   <= 4'd1;
                    end
`endif
                end
            end
`ifdef BUS_ARB_LOCK_EN
            else begin
                // Owner gone, lock released, or burst limit reached: hand the bus on.
                if (!bus.req[own] || !bus.lock[own] || (cnt + 4'd1 == 4'(BURST_MAX))) begin
                    state <= ARB;
                    ptr   <= own + 2'd1;
                    cnt   <= '0;
                end else begin
                    cnt   <= cnt + 4'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules and the two-beat pipeline.
module tb_bus_arbiter;

    localparam int DW        = 4;
    localparam int BURST_MAX = 4;
`ifdef BUS_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_arbiter_if #(.DW(DW)) bif ();

    bus_arbiter #(.DW(DW), .BURST_MAX(BURST_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: pointer, lock bookkeeping and a list of beats in flight.
    typedef struct {
        bit v;
        int d;
        int s;
    } beat_t;

    int    m_ptr, m_own, m_cnt;
    bit    m_locked;
    beat_t p1, p2;

    logic [3:0]    last_gnt;
    logic [DW-1:0] last_b;
    logic          last_valid;
    logic [1:0]    last_src;

    function automatic int onehot_idx(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    function automatic int lane(input int w);
        return int'((bif.a >> (w * DW)) & ((1 << DW) - 1));
    endfunction

    function automatic logic [3:0] model_gnt();
        if (rst || !bif.en || bif.req == 4'd0) return 4'd0;
        if (m_locked) return bif.req[m_own] ? 4'(1 << m_own) : 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (bif.req[(m_ptr + k) % 4]) return 4'(1 << ((m_ptr + k) % 4));
        end
        return 4'd0;
    endfunction

    function automatic void model_update(input logic [3:0] g);
        int w;
        if (rst) begin
            m_ptr = 0; m_own = 0; m_cnt = 0; m_locked = 0;
            p1 = '{1'b0, 0, 0};
            p2 = '{1'b0, 0, 0};
            return;
        end
        w  = onehot_idx(g);
        p2 = p1;
        if (g != 4'd0) p1 = '{1'b1, lane(w), w};
        else           p1.v = 1'b0;
        if (!bif.en) begin
            m_locked = 0;
            m_cnt    = 0;
        end else if (m_locked) begin
            if (!bif.req[m_own]) begin
                m_locked = 0;
                m_ptr    = (m_own + 1) % 4;
            end else begin
                m_cnt++;
                if (!bif.lock[m_own] || m_cnt == BURST_MAX) begin
                    m_locked = 0;
                    m_ptr    = (m_own + 1) % 4;
                end
            end
        end else if (g != 4'd0) begin
            m_ptr = (w + 1) % 4;
            if (LOCK_EN && bif.lock[w]) begin
                m_locked = 1;
                m_own    = w;
                m_cnt    = 1;
            end
        end
    endfunction

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic cycle(input string tag);
        logic [3:0] g;
        @(negedge clk);
        g          = model_gnt();
        last_gnt   = bif.gnt;
        last_b     = bif.b;
        last_valid = bif.b_valid;
        last_src   = bif.b_src;
        check({tag, "_gnt"},     32'(bif.gnt),     32'(g));
        check({tag, "_b_valid"}, 32'(bif.b_valid), 32'(p2.v));
        check({tag, "_b"},       32'(bif.b),       32'(p2.d));
        check({tag, "_b_src"},   32'(bif.b_src),   32'(p2.s));
        @(posedge clk);
        model_update(g);
        #1;
    endtask

    logic [3:0] seq030 [5];
    logic [3:0] seq033 [5];

    initial begin
        seq030 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq033 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};

        rst = 1'b1; bif.en = 1'b0; bif.req = '0; bif.lock = '0; bif.a = '0;
        @(posedge clk);
        model_update(4'd0);
        #1;

        // Idle after reset: everything quiet.
        rst = 1'b0; bif.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle("idle");
            check("idle_b_valid_zero", 32'(last_valid), 32'd0);
        end

        // All four requesting: strict rotation, data two cycles behind the grant.
        bif.req = 4'b1111; bif.a = 16'h4321;
        for (int i = 0; i < 7; i++) begin
            cycle("rr");
            if (i < 5) check("rr_gnt_seq", 32'(last_gnt), 32'(seq030[i]));
            if (i >= 2) begin
                check("rr_b_seq",   32'(last_b),   32'(((i - 2) % 4) + 1));
                check("rr_src_seq", 32'(last_src), 32'((i - 2) % 4));
            end
        end

        // Lone requester gets the bus every cycle.
        bif.req = 4'b0100; bif.a = 16'h0A00;
        for (int i = 0; i < 5; i++) begin
            cycle("lone");
            check("lone_gnt", 32'(last_gnt), 32'h4);
            if (i >= 2) begin
                check("lone_b",     32'(last_b),     32'hA);
                check("lone_valid", 32'(last_valid), 32'd1);
            end
        end

        // Enable dropped for three cycles while the pipeline drains.
        bif.req = 4'b1111; bif.a = 16'h4321;
        for (int i = 0; i < 3; i++) cycle("pre_en");
        bif.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("en_off");
            check("en_off_gnt", 32'(last_gnt), 32'd0);
            if (i == 2) check("en_off_drained", 32'(last_valid), 32'd0);
        end
        bif.en = 1'b1;
        for (int i = 0; i < 4; i++) cycle("en_on");

        // Locked burst from requester 0, then reset in the middle of a burst.
        rst = 1'b1; cycle("rst_a");
        rst = 1'b0; bif.req = 4'b1111; bif.lock = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            cycle("lock");
            if (LOCK_EN) check("lock_gnt_seq", 32'(last_gnt), 32'(seq033[i]));
        end
        for (int i = 0; i < 4; i++) cycle("lock_more");
        cycle("lock_mid");
        rst = 1'b1;
        cycle("rst_b");
        rst = 1'b0; bif.req = 4'b1110; bif.lock = 4'b0000;
        cycle("post_rst");
        check("post_rst_valid", 32'(last_valid), 32'd0);
        check("post_rst_gnt",   32'(last_gnt),   32'b0010);

        // Randomized traffic with occasional enable drops and resets.
        for (int i = 0; i < 400; i++) begin
            rst      = (($urandom % 60) == 0);
            bif.en   = (($urandom % 8) != 0);
            bif.req  = 4'($urandom);
            bif.lock = (($urandom % 2) == 0) ? 4'($urandom) : 4'd0;
            bif.a    = 16'($urandom);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
